dtw_result_axis_tx: RTL and testbench

AXI-Stream master that returns DTW core results to the PS/DMA. It is the transmit counterpart of the accelerator's AXI-Stream sample input. On each rising edge of the core's done flag it snapshots min_val, position and ref_len, then emits them as a 4-beat packet with TLAST. A one-deep pending buffer absorbs a result that arrives while a packet is in flight. Sits beside dtw_core in the accelerator top, on the same clock as the core.

---
 rtl/dtw_result_axis_tx_if.sv | 15 +
 rtl/dtw_result_axis_tx.sv | 172 +++++++++++++++++
 tb/tb_dtw_result_axis_tx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_result_axis_tx_if.sv
// AXI-Stream bundle for the DTW result transmitter.
//   tvalid/tdata/tstrb/tlast : master -> slave
//   tready                   : slave  -> master
interface dtw_result_axis_tx_if #(
    parameter int DATA_W = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/dtw_result_axis_tx.sv
// dtw_result_axis_tx: AXI-Stream master that returns DTW core results.
// On each rising edge of done (while enable is high) the result
// {min_val, position, ref_len} is snapshotted and sent as a 4-beat packet:
//   beat0 {HDR_MAGIC, seq[7:0], 7'b0, ovf}, beat1 min_val, beat2 position,
//   beat3 ref_len with tlast. A one-deep pending buffer absorbs one result
//   that arrives while a packet is in flight; further results are dropped.
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   enable            gate for new done edges
//   done              core done level
//   min_val/position/ref_len  result fields sampled on the done edge
//   m_axis            AXI-Stream master (tvalid/tready/tdata/tstrb/tlast)
//   busy              SEND state or pending buffer occupied
//   overflow          sticky, a result was dropped
//   pkt_count         completed packets, wraps
// Only a 32-bit stream width is supported.
module dtw_result_axis_tx #(
    parameter int          C_M_AXIS_TDATA_WIDTH = 32,
    parameter logic [15:0] HDR_MAGIC            = 16'hD7A0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        done,
    input  logic [31:0]                 min_val,
    input  logic [31:0]                 position,
    input  logic [31:0]                 ref_len,
    dtw_result_axis_tx_if.master        m_axis,
    output logic                        busy,
    output logic                        overflow,
    output logic [15:0]                 pkt_count
);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [31:0] min_val;
        logic [31:0] position;
        logic [31:0] ref_len;
        logic [7:0]  seq;
        logic        ovf;
    } snap_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    snap_t       act_q, act_d;
    snap_t       pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  seq_q, seq_d;
    logic        ovf_q, ovf_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q;

    logic        trig;
    logic        tvalid;
    logic        hs;
    logic        last_hs;
    snap_t       new_snap;

    // done_q resets low, so a done level already high right after reset
    // is seen as an edge.
    assign trig     = enable & done & ~done_q;
    assign tvalid   = (state_q == SEND);
    assign hs       = tvalid & m_axis.tready;
    assign last_hs  = hs & (beat_q == 2'd3);
    assign new_snap = '{min_val: min_val, position: position, ref_len: ref_len,
                        seq: seq_q, ovf: ovf_q};

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        seq_d      = seq_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (trig) begin
                    act_d   = new_snap;
                    seq_d   = seq_q + 8'd1;
                    beat_d  = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs)
                    beat_d = beat_q + 2'd1;   // 3 -> 0 wrap is intended

                if (last_hs) begin
                    cnt_d = cnt_q + 16'd1;
                    if (pend_vld_q) begin
                        // Pending becomes active with no bubble; a same-cycle
                        // trigger refills the just-freed pending slot.
                        act_d = pend_q;
                        if (trig) begin
                            pend_d = new_snap;
                            seq_d  = seq_q + 8'd1;
                        end else begin
                            pend_vld_d = 1'b0;
                        end
                    end else if (trig) begin
                        act_d = new_snap;
                        seq_d = seq_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trig) begin
                    if (!pend_vld_q) begin
                        pend_d     = new_snap;
                        pend_vld_d = 1'b1;
                        seq_d      = seq_q + 8'd1;
                    end else begin
                        // Drop. The queued packet also carries the flag so
                        // the host learns of the loss right after it.
                        ovf_d      = 1'b1;
                        pend_d.ovf = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= 2'd0;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seq_q      <= 8'd0;
            ovf_q      <= 1'b0;
            cnt_q      <= 16'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            seq_q      <= seq_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            done_q     <= done;
        end
    end

    // tdata is driven purely from registered state, so it is stable while
    // the slave stalls; it reads 0 whenever tvalid is low.
    always_comb begin
        m_axis.tdata = '0;
        if (tvalid) begin
            case (beat_q)
                2'd0:    m_axis.tdata = {HDR_MAGIC, act_q.seq, 7'b0, act_q.ovf};
                2'd1:    m_axis.tdata = act_q.min_val;
                2'd2:    m_axis.tdata = act_q.position;
                default: m_axis.tdata = act_q.ref_len;
            endcase
        end
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tvalid & (beat_q == 2'd3);
    assign m_axis.tstrb  = '1;
    assign busy          = tvalid | pend_vld_q;
    assign overflow      = ovf_q;
    assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_dtw_result_axis_tx.sv
module tb_dtw_result_axis_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        done;
    logic [31:0] min_val, position, ref_len;
    logic        busy, overflow;
    logic [15:0] pkt_count;

    dtw_result_axis_tx_if #(.DATA_W(32)) m_axis();

    dtw_result_axis_tx dut (
        .clk(clk), .rst(rst), .enable(enable), .done(done),
        .min_val(min_val), .position(position), .ref_len(ref_len),
        .m_axis(m_axis), .busy(busy), .overflow(overflow), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int gap_cnt = 0;
    bit gap_mon = 0;
    logic [32:0] exp_q[$];   // {tlast, tdata}
    logic        prev_stall = 0;
    logic [33:0] prev_bus;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] seq, input logic ovf);
        return {16'hD7A0, seq, 7'b0, ovf};
    endfunction

    task automatic push_pkt(input logic [31:0] h, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c);
        exp_q.push_back({1'b0, h});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b1, c});
    endtask

    // Handshakes are judged at negedge with inputs already settled, so a
    // pop here corresponds to the transfer on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall)
                chk("hold", 64'({m_axis.tvalid, m_axis.tlast, m_axis.tdata}), 64'(prev_bus));
            if (m_axis.tvalid && m_axis.tready) begin
                hs_cnt++;
                if (exp_q.size() == 0)
                    chk("extra_beat", 64'({m_axis.tlast, m_axis.tdata}), 64'hDEAD_0000_0000);
                else
                    chk("beat", 64'({m_axis.tlast, m_axis.tdata}), 64'(exp_q.pop_front()));
            end
            if (gap_mon && !m_axis.tvalid && exp_q.size() != 0)
                gap_cnt++;
            prev_stall = m_axis.tvalid & ~m_axis.tready;
            prev_bus   = {m_axis.tvalid, m_axis.tlast, m_axis.tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1; done = 1'b0; enable = 1'b1; m_axis.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic set_res(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        min_val = a; position = b; ref_len = c;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag, input int max_cyc, input bit bp);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            m_axis.tready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        m_axis.tready = 1'b1;
    endtask

    initial begin
        int h0;
        min_val = '0; position = '0; ref_len = '0;
        do_reset();

        // Reset state
        chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("rst_tlast",  64'(m_axis.tlast),  64'd0);
        chk("rst_tdata",  64'(m_axis.tdata),  64'd0);
        chk("rst_busy",   64'(busy),          64'd0);
        chk("rst_ovf",    64'(overflow),      64'd0);
        chk("rst_cnt",    64'(pkt_count),     64'd0);
        chk("tstrb",      64'(m_axis.tstrb),  64'hF);

        // Single result, 1-cycle latency
        set_res(32'h0000_1234, 32'h0000_0100, 32'd29898);
        push_pkt(32'hD7A0_0000, 32'h0000_1234, 32'h0000_0100, 32'h0000_74CA);
        done = 1'b1;
        @(posedge clk); #1;
        chk("lat_tvalid", 64'(m_axis.tvalid), 64'd1);
        drain("single", 20, 0);
        done = 1'b0;
        chk("single_cnt", 64'(pkt_count), 64'd1);
        chk("single_busy", 64'(busy), 64'd0);

        // Backpressure
        do_reset();
        h0 = hs_cnt;
        push_pkt(hdr(8'd0, 1'b0), 32'h0000_1234, 32'h0000_0100, 32'h0000_74CA);
        m_axis.tready = 1'b0;
        pulse_done();
        drain("bp", 40, 1);
        chk("bp_hs", 64'(hs_cnt - h0), 64'd4);
        chk("bp_cnt", 64'(pkt_count), 64'd1);

        // Pending back-to-back
        do_reset();
        m_axis.tready = 1'b0;
        set_res(32'hAAAA_0001, 32'h0000_0011, 32'h0000_0021);
        push_pkt(hdr(8'd0, 1'b0), 32'hAAAA_0001, 32'h0000_0011, 32'h0000_0021);
        pulse_done();
        set_res(32'hBBBB_0002, 32'h0000_0012, 32'h0000_0022);
        push_pkt(hdr(8'd1, 1'b0), 32'hBBBB_0002, 32'h0000_0012, 32'h0000_0022);
        pulse_done();
        chk("b2b_busy", 64'(busy), 64'd1);
        gap_cnt = 0; gap_mon = 1;
        drain("b2b", 30, 0);
        gap_mon = 0;
        chk("b2b_gaps", 64'(gap_cnt), 64'd0);
        chk("b2b_ovf", 64'(overflow), 64'd0);
        chk("b2b_cnt", 64'(pkt_count), 64'd2);

        // Overflow
        do_reset();
        m_axis.tready = 1'b0;
        set_res(32'h1, 32'h2, 32'h3);
        push_pkt(hdr(8'd0, 1'b0), 32'h1, 32'h2, 32'h3);
        pulse_done();
        set_res(32'h4, 32'h5, 32'h6);
        push_pkt(hdr(8'd1, 1'b1), 32'h4, 32'h5, 32'h6);
        pulse_done();
        chk("ovf_before", 64'(overflow), 64'd0);
        set_res(32'h7, 32'h8, 32'h9);
        pulse_done();
        chk("ovf_set", 64'(overflow), 64'd1);
        drain("ovf", 30, 0);
        set_res(32'hA, 32'hB, 32'hC);
        push_pkt(hdr(8'd2, 1'b1), 32'hA, 32'hB, 32'hC);
        pulse_done();
        drain("ovf_next", 20, 0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_cnt", 64'(pkt_count), 64'd3);

        // Enable / level
        do_reset();
        set_res(32'h55, 32'h66, 32'h77);
        push_pkt(hdr(8'd0, 1'b0), 32'h55, 32'h66, 32'h77);
        done = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("lvl_empty", 64'(exp_q.size()), 64'd0);
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lvl_cnt", 64'(pkt_count), 64'd1);
        enable = 1'b0;
        pulse_done();
        repeat (6) @(posedge clk);
        #1;
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_cnt", 64'(pkt_count), 64'd1);
        enable = 1'b1;

        // Reset mid-packet
        do_reset();
        m_axis.tready = 1'b0;
        set_res(32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003);
        push_pkt(hdr(8'd0, 1'b0), 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003);
        pulse_done();
        pulse_done();   // second edge lands in pending before the reset
        m_axis.tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_left", 64'(exp_q.size()), 64'd2);
        rst = 1'b1; m_axis.tready = 1'b0;
        @(posedge clk); #1;
        chk("mid_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("mid_cnt", 64'(pkt_count), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        m_axis.tready = 1'b1;
        set_res(32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        push_pkt(hdr(8'd0, 1'b0), 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        pulse_done();
        drain("mid_next", 20, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_next_cnt", 64'(pkt_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
